// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control
// Description : Stall/flush sequencer for a 5-stage pipeline (IF, ID, EX, MEM,
//               WB). Merges load-use stalls, taken-branch flushes, multi-cycle
//               mult/div occupancy of EX and data-memory waits into per-stage
//               register enables and flushes. Keeps stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control #(
    parameter int MD_CYCLES = 4,   // total EX cycles of a mult/div (>= 2)
    parameter int CNT_W     = 4    // down-counter width, 2**CNT_W >= MD_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_id,
    input  logic        branch_taken_ex,
    input  logic        md_start_ex,
    input  logic        dmem_wait,
    input  logic        perf_clr,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    // The start cycle itself is one of the MD_CYCLES, and the cnt==0 cycle is
    // the completion cycle, so the counter starts at MD_CYCLES-2.
    localparam logic [CNT_W-1:0] c_MD_INIT = CNT_W'(MD_CYCLES - 2);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_stall_cycles;
    logic [15:0]       r_flush_count;

    logic              w_md_busy;
    logic              w_cnt_zero;

    assign w_md_busy  = (r_state == ST_MULDIV);
    assign w_cnt_zero = (r_cnt == '0);

    // Enable/flush decode; reset and dmem_wait both force a full freeze.
    always_comb begin
        en_pc        = 1'b0;
        en_if_id     = 1'b0;
        en_id_ex     = 1'b0;
        en_ex_mem    = 1'b0;
        en_mem_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        md_done      = 1'b0;
        if (reset || dmem_wait) begin
            // everything stays at the frozen defaults
        end else if (w_md_busy) begin
            if (!w_cnt_zero) begin
                // EX still busy: hold front end, bubble into MEM
                en_ex_mem    = 1'b1;
                flush_ex_mem = 1'b1;
                en_mem_wb    = 1'b1;
            end else begin
                en_pc     = 1'b1;
                en_if_id  = 1'b1;
                en_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
                md_done   = 1'b1;
            end
        end else if (md_start_ex) begin
            en_ex_mem    = 1'b1;
            flush_ex_mem = 1'b1;
            en_mem_wb    = 1'b1;
        end else if (branch_taken_ex) begin
            // ID instruction is squashed, so any load-use stall is moot
            en_pc       = 1'b1;
            en_if_id    = 1'b1;
            en_id_ex    = 1'b1;
            en_ex_mem   = 1'b1;
            en_mem_wb   = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (stall_id) begin
            en_id_ex    = 1'b1;
            flush_id_ex = 1'b1;
            en_ex_mem   = 1'b1;
            en_mem_wb   = 1'b1;
        end else begin
            en_pc     = 1'b1;
            en_if_id  = 1'b1;
            en_id_ex  = 1'b1;
            en_ex_mem = 1'b1;
            en_mem_wb = 1'b1;
        end
    end

    assign md_busy = w_md_busy && !reset;

    // Mult/div sequencer: state and down-counter hold during memory waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (!dmem_wait) begin
            case (r_state)
                ST_RUN: begin
                    if (md_start_ex) begin
                        r_cnt   <= c_MD_INIT;
                        r_state <= ST_MULDIV;
                    end
                end
                ST_MULDIV: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Performance counters: stall count wraps, flush count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (perf_clr) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!en_pc) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush_if_id && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire
